// File: rtl/serial_rcv_ctrl.sv
// Receive-side control for the APB serial peripheral: start-bit qualification,
// bit-timer sequencing, stop-bit check, holding register and sticky error flags.
module serial_rcv_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 serial_in,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 shift_strobe,
  input  logic                 packet_done,
  input  logic                 data_read,
  input  logic                 err_clear,
  output logic                 enable_timer,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] LAST_STROBE = CW'(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_CHK = 3'd1,
    S_RECEIVE   = 3'd2,
    S_STOP_CHK  = 3'd3,
    S_LOAD      = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, rx_s_q, rx_q;
  logic [DIV_WIDTH-1:0]   half_q, half_d;
  logic [DIV_WIDTH-1:0]   half_cnt_q, half_cnt_d;
  logic [CW-1:0]          strobe_cnt_q, strobe_cnt_d;
  logic [DATA_BITS:0]     sr_q, sr_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   data_ready_q, data_ready_d;
  logic                   fe_q, fe_d;
  logic                   oe_q, oe_d;
  logic                   fall;
  logic [DIV_WIDTH-1:0]   half_raw, half_new;

  assign fall     = rx_q & ~rx_s_q;
  assign half_raw = baud_div >> 1;
  // A divisor of 0 or 1 would give an empty start check; clamp to one cycle.
  assign half_new = (half_raw == '0) ? DIV_WIDTH'(1) : half_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_q         <= 1'b1;
      half_q       <= DIV_WIDTH'(1);
      half_cnt_q   <= '0;
      strobe_cnt_q <= '0;
      sr_q         <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      fe_q         <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= serial_in;
      rx_s_q       <= sync1_q;
      rx_q         <= rx_s_q;
      half_q       <= half_d;
      half_cnt_q   <= half_cnt_d;
      strobe_cnt_q <= strobe_cnt_d;
      sr_q         <= sr_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      fe_q         <= fe_d;
      oe_q         <= oe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    half_cnt_d   = half_cnt_q;
    strobe_cnt_d = strobe_cnt_q;
    sr_d         = sr_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_read ? 1'b0 : data_ready_q;
    fe_d         = err_clear ? 1'b0 : fe_q;
    oe_d         = err_clear ? 1'b0 : oe_q;

    case (state_q)
      S_IDLE: begin
        strobe_cnt_d = '0;
        if (rx_enable && fall) begin
          state_d    = S_START_CHK;
          half_d     = half_new;
          half_cnt_d = '0;
        end
      end
      S_START_CHK: begin
        if (!rx_enable || rx_s_q) begin
          state_d = S_IDLE;
        end else if (half_cnt_q == half_q - DIV_WIDTH'(1)) begin
          state_d = S_RECEIVE;
        end else begin
          half_cnt_d = half_cnt_q + DIV_WIDTH'(1);
        end
      end
      S_RECEIVE: begin
        if (!rx_enable) begin
          state_d = S_IDLE;
        end else if (shift_strobe) begin
          sr_d         = {rx_s_q, sr_q[DATA_BITS:1]};
          strobe_cnt_d = strobe_cnt_q + CW'(1);
          // The final strobe outranks a coincident packet_done.
          if (strobe_cnt_q == LAST_STROBE) begin
            state_d = S_STOP_CHK;
          end else if (packet_done) begin
            fe_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (packet_done) begin
          fe_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STOP_CHK: begin
        state_d = S_IDLE;
        if (rx_enable) begin
          if (sr_q[DATA_BITS]) state_d = S_LOAD;
          else                 fe_d    = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        if (rx_enable) begin
          rx_data_d    = sr_q[DATA_BITS-1:0];
          data_ready_d = 1'b1;
          if (data_ready_q && !data_read) oe_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enable_timer  = (state_q == S_RECEIVE);
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;
  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;

endmodule
